// File: rtl/fpga_boot_pkg.sv
// rtl/fpga_boot_pkg.sv - shared state encoding and constants for the FPGA boot sequencer
package fpga_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } boot_state_t;

    // Wide enough for the largest hold time (255 cycles).
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/fpga_sync_2ff.sv
// rtl/fpga_sync_2ff.sv - two-flop synchronizer for one asynchronous strap pad
module fpga_sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/fpga_boot_sequencer.sv
// rtl/fpga_boot_sequencer.sv - sequences PLL lock, SoC reset release, strap latching and exit status
module fpga_boot_sequencer
    import fpga_boot_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned LOCK_FILTER_CYCLES = 4,
    parameter int unsigned LED_CNT_LEN        = 24
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pll_locked_i,
    input  logic        boot_select_pad_i,
    input  logic        execute_from_flash_pad_i,
    input  logic        soft_restart_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        soc_rst_no,
    output logic        boot_select_o,
    output logic        execute_from_flash_o,
    output logic [2:0]  state_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] exit_code_o,
    output logic        status_led_o
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

    boot_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [LED_CNT_LEN-1:0] led_cnt;
    logic                   boot_select_sync;
    logic                   execute_from_flash_sync;

    fpga_sync_2ff u_sync_boot_select (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (boot_select_pad_i),
        .q_o    (boot_select_sync)
    );

    fpga_sync_2ff u_sync_execute_from_flash (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (execute_from_flash_pad_i),
        .q_o    (execute_from_flash_sync)
    );

    assign state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            soc_rst_no           <= 1'b0;
            boot_select_o        <= 1'b0;
            execute_from_flash_o <= 1'b0;
            done_o               <= 1'b0;
            pass_o               <= 1'b0;
            exit_code_o          <= '0;
        end else if (state != ST_IDLE && !pll_locked_i) begin
            // Losing lock overrides every other event, whatever the state.
            state       <= ST_IDLE;
            cnt         <= '0;
            soc_rst_no  <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            exit_code_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt        <= '0;
                    soc_rst_no <= 1'b0;
                    if (pll_locked_i) state <= ST_LOCK_WAIT;
                end
                ST_LOCK_WAIT: begin
                    if (cnt == LOCK_LAST) begin
                        cnt   <= '0;
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt                  <= '0;
                        state                <= ST_RUN;
                        soc_rst_no           <= 1'b1;
                        boot_select_o        <= boot_select_sync;
                        execute_from_flash_o <= execute_from_flash_sync;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Restart takes priority over a coincident exit strobe.
                    if (soft_restart_i) begin
                        state      <= ST_HOLD;
                        cnt        <= '0;
                        soc_rst_no <= 1'b0;
                    end else if (exit_valid_i) begin
                        state       <= ST_DONE;
                        exit_code_o <= exit_value_i;
                        done_o      <= 1'b1;
                        pass_o      <= (exit_value_i == 32'd0);
                    end
                end
                ST_DONE: begin
                    if (soft_restart_i) begin
                        state       <= ST_HOLD;
                        cnt         <= '0;
                        soc_rst_no  <= 1'b0;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        exit_code_o <= '0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cnt        <= '0;
                    soc_rst_no <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_cnt      <= '0;
            status_led_o <= 1'b0;
        end else begin
            led_cnt <= led_cnt + 1'b1;
            case (state)
                ST_HOLD: status_led_o <= 1'b1;
                ST_RUN:  status_led_o <= led_cnt[LED_CNT_LEN-1];
                ST_DONE: status_led_o <= pass_o ? 1'b1 : led_cnt[LED_CNT_LEN-3];
                default: status_led_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/fpga_boot_sequencer.md
FPGA_BOOT_SEQUENCER -- requirements
Module: fpga_boot_sequencer

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 16: cycles soc reset is held after clock is stable (range 2..255).
REQ-002 Parameter LOCK_FILTER_CYCLES, default 4: consecutive locked cycles required before leaving IDLE (range 1..15).
REQ-003 Parameter LED_CNT_LEN, default 24: width of the status LED blink counter (min 4).
REQ-004 clk_i  in  1  generated SoC clock; single clock domain.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 pll_locked_i  in  1  clock wizard lock indication.
REQ-007 boot_select_pad_i, execute_from_flash_pad_i  in  1 each  raw strap pads, asynchronous.
REQ-008 soft_restart_i  in  1  single-cycle restart request.
REQ-009 exit_valid_i  in  1  SoC program-exit strobe; exit_value_i  in  32  SoC exit code.
REQ-010 soc_rst_no  out  1  active-low SoC reset.
REQ-011 boot_select_o, execute_from_flash_o  out  1 each  latched straps to SoC.
REQ-012 state_o  out  3  encoded FSM state; done_o, pass_o  out  1 each; exit_code_o  out  32.
REQ-013 status_led_o  out  1  board status LED.

Function
REQ-014 FSM states, encoding: IDLE=0, LOCK_WAIT=1, HOLD=2, RUN=3, DONE=4.
REQ-015 IDLE: soc_rst_no=0; goes to LOCK_WAIT when pll_locked_i=1.
REQ-016 LOCK_WAIT: counter increments each locked cycle; pll_locked_i=0 clears counter and returns to IDLE; reaching LOCK_FILTER_CYCLES goes to HOLD.
REQ-017 HOLD: soc_rst_no=0; counter counts RST_HOLD_CYCLES cycles, then goes to RUN.
REQ-018 Straps pass through a 2-flop synchronizer; synchronized values are latched into boot_select_o/execute_from_flash_o on the HOLD->RUN transition cycle and held constant outside HOLD.
REQ-019 RUN: soc_rst_no=1 (registered, first high cycle is the first cycle in RUN); exit_valid_i=1 latches exit_value_i into exit_code_o and goes to DONE.
REQ-020 DONE: soc_rst_no stays 1; done_o=1; pass_o=1 iff exit_code_o==0; further exit_valid_i ignored.
REQ-021 soft_restart_i=1 in RUN or DONE goes to HOLD, clears done_o, pass_o, exit_code_o, asserts soc_rst_no=0 next cycle; ignored in IDLE, LOCK_WAIT, HOLD.
REQ-022 pll_locked_i=0 in any state except IDLE goes to IDLE next cycle, overriding all other events; soc_rst_no=0 that cycle onward; exit results cleared.
REQ-023 Simultaneous exit_valid_i and soft_restart_i in RUN: soft_restart wins.
REQ-024 status_led_o: IDLE/LOCK_WAIT 0; HOLD 1; RUN = LED counter MSB; DONE pass 1 steady; DONE fail = LED counter bit LED_CNT_LEN-3 (4x blink rate).
REQ-025 LED counter free-runs, wraps modulo 2^LED_CNT_LEN, not cleared by FSM transitions.
REQ-026 All outputs registered; no combinational input-to-output paths.

Reset
REQ-027 On rst_ni=0: state IDLE, soc_rst_no=0, boot_select_o=0, execute_from_flash_o=0, done_o=0, pass_o=0, exit_code_o=0, status_led_o=0, all counters and synchronizer flops 0.
REQ-028 Reset assertion mid-RUN asserts soc_rst_no=0 immediately (asynchronously); release follows the full IDLE->LOCK_WAIT->HOLD sequence.

Structure
REQ-029 State enum type and state encoding constants reside in shared package fpga_boot_pkg.
REQ-030 Strap synchronizer is one sub-module, fpga_sync_2ff, instanced per strap bit.
REQ-031 Block instantiated in the FPGA top between the clock wizard and the SoC, driving SoC rst_ni and boot straps.

Verification
REQ-032 Lock at cycle 10, LOCK_FILTER=4, RST_HOLD=16 -> soc_rst_no rises exactly 4+16+1 cycles after first locked cycle (HOLD->RUN), state_o=3.
REQ-033 Lock glitch low for 1 cycle during LOCK_WAIT count 3 -> state_o=0, counter restarts; soc_rst_no stays 0.
REQ-034 Straps boot_select=1, execute_from_flash=0 during HOLD, toggled to 0/1 in RUN -> outputs stay 1/0.
REQ-035 exit_valid_i with exit_value_i=0 -> done_o=1, pass_o=1, status_led_o=1; with 0x0000_0005 -> pass_o=0, exit_code_o=5, LED blinks at bit LED_CNT_LEN-3.
REQ-036 soft_restart_i and exit_valid_i same cycle in RUN -> state_o=2, done_o=0, soc_rst_no=0 next cycle, re-release after 16 cycles.
REQ-037 pll_locked_i dropped in DONE -> state_o=0, soc_rst_no=0, exit_code_o=0 next cycle.
